fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter NUM_INST, default 15, number of program ROM words.
REQ-003 SHALL have parameter AW, default 4, PC/ROM address width, with NUM_INST <= 2**AW.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port start, input, 1, begin fetch at PC 0 from IDLE or HALT.
REQ-007 SHALL have port rom_en, output, 1, ROM read strobe.
REQ-008 SHALL have port rom_addr, output, AW, ROM word address.
REQ-009 SHALL have port rom_data, input, WIDTH, ROM read data, valid the cycle after rom_en.
REQ-010 SHALL have port inst, output, WIDTH, instruction presented to decode.
REQ-011 SHALL have port inst_pc, output, AW, PC of inst.
REQ-012 SHALL have port inst_valid, output, 1, inst is valid.
REQ-013 SHALL have port inst_ready, input, 1, decode accepts inst.
REQ-014 SHALL have port redirect_valid, input, 1, PC redirect request.
REQ-015 SHALL have port redirect_pc, input, AW, redirect target.
REQ-016 SHALL have port halted, output, 1, sequencer is in HALT.
REQ-017 SHALL have port fault, output, 1, sticky flag for an out-of-range redirect.
REQ-018 SHALL have port issued_cnt, output, 16, saturating count of accepted instructions.

Function
REQ-019 SHALL implement the states IDLE, FETCH, WAIT, ISSUE and HALT.
REQ-020 IDLE/HALT: on start, SHALL set pc=0, clear issued_cnt and fault, and go to FETCH; all other inputs are ignored in these states.
REQ-021 FETCH: SHALL drive rom_en=1 and rom_addr=pc for exactly one cycle, then go to WAIT.
REQ-022 WAIT: SHALL capture rom_data into inst and pc into inst_pc; if rom_data==0 (NO-OP terminator) SHALL go to HALT without asserting inst_valid, otherwise SHALL go to ISSUE.
REQ-023 ISSUE: SHALL hold inst_valid=1, with inst and inst_pc stable, until inst_valid&inst_ready.
REQ-024 On handshake: SHALL increment issued_cnt (saturating at 16'hFFFF) and set pc=pc+1; if pc+1==NUM_INST SHALL go to HALT, else to FETCH.
REQ-025 Minimum issue interval SHALL be 3 cycles (FETCH, WAIT, ISSUE).
REQ-026 redirect_valid in FETCH/WAIT/ISSUE SHALL take priority over the handshake and the WAIT capture: inst_valid drops next cycle, the instruction is not counted, pc=redirect_pc, and the next state is FETCH.
REQ-027 A redirect with redirect_pc>=NUM_INST SHALL set fault=1 and go to HALT.
REQ-028 rom_en SHALL be 0 in all states except FETCH; inst_valid SHALL be 0 in all states except ISSUE.
REQ-029 halted SHALL equal 1 exactly when the state is HALT.

Reset
REQ-030 On rst, the state SHALL be IDLE, with pc=0, inst=0, inst_pc=0, inst_valid=0, rom_en=0, rom_addr=0, halted=0, fault=0 and issued_cnt=0.
REQ-031 rst SHALL override all inputs and SHALL abort any transfer in progress; a held inst is discarded.

Configuration
REQ-032 With macro FETCH_STALL_CNT_EN defined, SHALL add output stall_cnt (16 bits) counting ISSUE cycles with inst_valid&!inst_ready, saturating, cleared by rst and start.
REQ-033 Without FETCH_STALL_CNT_EN defined, neither the port nor its counter SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then a 1-cycle start, then inst_ready=1 with ROM {A,B,0} -> A at pc0, B at pc1; HALT after the zero word; issued_cnt=2; halted=1.
REQ-035 Full 15-word ROM with no zero word -> 15 handshakes, 3 cycles apart; HALT after pc=14; issued_cnt=15.
REQ-036 inst_ready held low for 5 cycles in ISSUE -> inst and inst_pc stable, inst_valid=1 throughout; with FETCH_STALL_CNT_EN, stall_cnt=5.
REQ-037 redirect_valid=1 with redirect_pc=7 in the same cycle as a handshake at pc=2 -> that instruction is not counted; the next fetch is rom_addr=7.
REQ-038 redirect_pc=15 with NUM_INST=15 -> fault=1, halted=1; a following start clears fault and fetches pc0.
REQ-039 rst asserted in ISSUE -> next cycle inst_valid=0, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer: reads a program ROM word by word,
//               presents each word to decode with a valid/ready handshake,
//               honours PC redirects and halts on a zero word or at program end.
//               Optional macro FETCH_STALL_CNT_EN adds a decode-stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int WIDTH    = 32,
    parameter int NUM_INST = 15,
    parameter int AW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             rom_en,
    output logic [AW-1:0]    rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] inst,
    output logic [AW-1:0]    inst_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic             redirect_valid,
    input  logic [AW-1:0]    redirect_pc,
    output logic             halted,
    output logic             fault,
    output logic [15:0]      issued_cnt
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_ISSUE = 3'd3;
    localparam logic [2:0] c_HALT  = 3'd4;

    // One extra bit so NUM_INST == 2**AW still compares correctly.
    localparam logic [AW:0] c_NUM_INST = (AW+1)'(NUM_INST);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [AW-1:0]    r_pc;
    logic [WIDTH-1:0] r_inst;
    logic [AW-1:0]    r_inst_pc;
    logic [15:0]      r_issued_cnt;
    logic             r_fault;

    logic             w_active;
    logic             w_redirect;
    logic             w_redirect_bad;
    logic             w_start;
    logic             w_handshake;
    logic [AW:0]      w_pc_inc;
    logic             w_last;

    assign w_active       = (r_state == c_FETCH) || (r_state == c_WAIT) || (r_state == c_ISSUE);
    assign w_redirect     = w_active && redirect_valid;
    assign w_redirect_bad = ({1'b0, redirect_pc} >= c_NUM_INST);
    assign w_start        = ((r_state == c_IDLE) || (r_state == c_HALT)) && start;
    assign w_handshake    = (r_state == c_ISSUE) && inst_ready;
    assign w_pc_inc       = {1'b0, r_pc} + {{AW{1'b0}}, 1'b1};
    assign w_last         = (w_pc_inc == c_NUM_INST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_HALT: begin
                if (start) begin
                    w_next_state = c_FETCH;
                end
            end
            c_FETCH: begin
                if (w_redirect) begin
                    w_next_state = w_redirect_bad ? c_HALT : c_FETCH;
                end else begin
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                if (w_redirect) begin
                    w_next_state = w_redirect_bad ? c_HALT : c_FETCH;
                end else if (rom_data == '0) begin
                    w_next_state = c_HALT;
                end else begin
                    w_next_state = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_redirect) begin
                    w_next_state = w_redirect_bad ? c_HALT : c_FETCH;
                end else if (inst_ready) begin
                    w_next_state = w_last ? c_HALT : c_FETCH;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        rom_en     = 1'b0;
        rom_addr   = '0;
        inst_valid = 1'b0;
        halted     = 1'b0;
        case (r_state)
            c_FETCH: begin
                rom_en   = 1'b1;
                rom_addr = r_pc;
            end
            c_ISSUE: inst_valid = 1'b1;
            c_HALT:  halted     = 1'b1;
            default: ;
        endcase
    end

    // Redirect wins over both the WAIT capture and the ISSUE handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_issued_cnt <= '0;
            r_fault      <= 1'b0;
        end else if (w_start) begin
            r_pc         <= '0;
            r_issued_cnt <= '0;
            r_fault      <= 1'b0;
        end else if (w_redirect) begin
            if (w_redirect_bad) begin
                r_fault <= 1'b1;
            end else begin
                r_pc <= redirect_pc;
            end
        end else begin
            if (r_state == c_WAIT) begin
                r_inst    <= rom_data;
                r_inst_pc <= r_pc;
            end
            if (w_handshake) begin
                r_pc <= w_pc_inc[AW-1:0];
                if (r_issued_cnt != 16'hFFFF) begin
                    r_issued_cnt <= r_issued_cnt + 16'd1;
                end
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_ISSUE) && !inst_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign fault      = r_fault;
    assign issued_cnt = r_issued_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer with a
//               one-cycle-latency ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

    localparam int WIDTH    = 32;
    localparam int NUM_INST = 15;
    localparam int AW       = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             rom_en;
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_data = '0;
    logic [WIDTH-1:0] inst;
    logic [AW-1:0]    inst_pc;
    logic             inst_valid;
    logic             inst_ready = 1'b0;
    logic             redirect_valid = 1'b0;
    logic [AW-1:0]    redirect_pc = '0;
    logic             halted;
    logic             fault;
    logic [15:0]      issued_cnt;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    logic [WIDTH-1:0] rom [0:15];
    int               check_cnt = 0;
    int               pass_cnt  = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.WIDTH(WIDTH), .NUM_INST(NUM_INST), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fault          (fault),
        .issued_cnt     (issued_cnt)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Ticks until inst_valid (bounded) and checks the number of cycles taken.
    task automatic wait_valid(input int exp_n, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!inst_valid && n < 20);
        check(tag, n, exp_n);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0] = 32'hA5A5_0001;
        rom[1] = 32'h5A5A_0002;
        rom[2] = 32'h0000_0000;

        // Reset state
        tick();
        tick();
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_issued", issued_cnt, 0);
        rst = 1'b0;
        tick();
        check("idle_rom_en", rom_en, 0);

        // Short program terminated by a zero word
        start = 1'b1;
        tick();
        start = 1'b0;
        inst_ready = 1'b1;
        check("p1_fetch_en", rom_en, 1);
        check("p1_fetch_addr", rom_addr, 0);
        wait_valid(2, "p1_lat0");
        check("p1_inst0", inst, 32'hA5A5_0001);
        check("p1_pc0", inst_pc, 0);
        wait_valid(3, "p1_lat1");
        check("p1_inst1", inst, 32'h5A5A_0002);
        check("p1_pc1", inst_pc, 1);
        tick();
        check("p1_fetch2_addr", rom_addr, 2);
        tick();
        check("p1_wait_valid", inst_valid, 0);
        tick();
        check("p1_halted", halted, 1);
        check("p1_no_valid", inst_valid, 0);
        check("p1_issued", issued_cnt, 2);
        check("p1_fault", fault, 0);

        // Full 15-word program, no zero word
        for (int i = 0; i < 16; i++) rom[i] = 32'h100 + i;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("p2_start_issued", issued_cnt, 0);
        check("p2_start_halted", halted, 0);
        for (int i = 0; i < NUM_INST; i++) begin
            if (i == 0) wait_valid(2, "p2_lat");
            else        wait_valid(3, "p2_interval");
            check("p2_inst", inst, 32'h100 + i);
            check("p2_pc", inst_pc, i);
        end
        tick();
        check("p2_halted", halted, 1);
        check("p2_issued", issued_cnt, 15);
        check("p2_rom_en", rom_en, 0);

        // Decode stall for five cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        inst_ready = 1'b0;
        wait_valid(2, "p3_lat");
        for (int k = 0; k < 5; k++) begin
            check("p3_stall_valid", inst_valid, 1);
            check("p3_stall_inst", inst, 32'h100);
            check("p3_stall_pc", inst_pc, 0);
            tick();
        end
        check("p3_still_valid", inst_valid, 1);
        check("p3_still_inst", inst, 32'h100);
`ifdef FETCH_STALL_CNT_EN
        check("p3_stall_cnt", stall_cnt, 5);
`endif
        inst_ready = 1'b1;
        tick();
        check("p3_hs_issued", issued_cnt, 1);
        check("p3_hs_valid", inst_valid, 0);
        check("p3_hs_addr", rom_addr, 1);
`ifdef FETCH_STALL_CNT_EN
        check("p3_stall_hold", stall_cnt, 5);
`endif

        // Redirect coincident with a handshake at pc 2
        wait_valid(2, "p4_lat1");
        check("p4_inst1", inst, 32'h101);
        tick();
        wait_valid(2, "p4_lat2");
        check("p4_pc2", inst_pc, 2);
        check("p4_inst2", inst, 32'h102);
        redirect_valid = 1'b1;
        redirect_pc    = 4'd7;
        tick();
        redirect_valid = 1'b0;
        check("p4_redir_en", rom_en, 1);
        check("p4_redir_addr", rom_addr, 7);
        check("p4_redir_valid", inst_valid, 0);
        check("p4_redir_issued", issued_cnt, 2);
        wait_valid(2, "p4_lat7");
        check("p4_inst7", inst, 32'h107);
        check("p4_pc7", inst_pc, 7);

        // Out-of-range redirect faults and halts
        redirect_valid = 1'b1;
        redirect_pc    = 4'd15;
        tick();
        redirect_valid = 1'b0;
        check("p5_fault", fault, 1);
        check("p5_halted", halted, 1);
        check("p5_valid", inst_valid, 0);
        check("p5_issued", issued_cnt, 2);
        redirect_valid = 1'b1;
        redirect_pc    = 4'd3;
        tick();
        redirect_valid = 1'b0;
        check("p5_halt_ignores", halted, 1);
        check("p5_halt_rom_en", rom_en, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        inst_ready = 1'b0;
        check("p5_restart_fault", fault, 0);
        check("p5_restart_halted", halted, 0);
        check("p5_restart_en", rom_en, 1);
        check("p5_restart_addr", rom_addr, 0);
        check("p5_restart_issued", issued_cnt, 0);

        // Reset while an instruction is held in ISSUE
        wait_valid(2, "p6_lat");
        check("p6_held_inst", inst, 32'h100);
        rst = 1'b1;
        tick();
        check("p6_rst_valid", inst_valid, 0);
        check("p6_rst_inst", inst, 0);
        check("p6_rst_pc", inst_pc, 0);
        check("p6_rst_rom_en", rom_en, 0);
        check("p6_rst_halted", halted, 0);
        check("p6_rst_fault", fault, 0);
        check("p6_rst_issued", issued_cnt, 0);
        rst = 1'b0;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("p6_idle_rom_en", rom_en, 0);
        check("p6_idle_valid", inst_valid, 0);
        check("p6_idle_halted", halted, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

`default_nettype wire
